// File: rtl/ks_pkg.sv
// Shared constants and types for the Kogge-Stone subtractor.
// Stage records carry the prefix G/P pair plus the bitwise propagate and carry-in needed for the final XOR.
package ks_pkg;

  localparam int KS_WIDTH   = 16;
  localparam int KS_LATENCY = 6;
  localparam int KS_LEVELS  = 4;

  typedef struct packed {
    logic [KS_WIDTH-1:0] g;
    logic [KS_WIDTH-1:0] p;
  } gp_t;

  typedef struct packed {
    gp_t                 gp;
    logic [KS_WIDTH-1:0] p0;
    logic                cin;
  } ks_stage_t;

  function automatic logic [4:0] ks_span(input int level);
    return 5'(1 << level);
  endfunction

endpackage

// File: rtl/ks_subtractor_if.sv
// Operand/result bundle for ks_subtractor.
// Ovf exists only when KS_SUB_OVERFLOW_EN is defined.
interface ks_subtractor_if;
  import ks_pkg::*;

  logic                ce;
  logic                in_valid;
  logic [KS_WIDTH-1:0] A;
  logic [KS_WIDTH-1:0] B;
  logic                Bin;
  logic [KS_WIDTH-1:0] Diff;
  logic                Bout;
  logic                out_valid;
`ifdef KS_SUB_OVERFLOW_EN
  logic                Ovf;
`endif

  modport master (
    output ce, in_valid, A, B, Bin,
`ifdef KS_SUB_OVERFLOW_EN
    input  Ovf,
`endif
    input  Diff, Bout, out_valid
  );

  modport slave (
    input  ce, in_valid, A, B, Bin,
`ifdef KS_SUB_OVERFLOW_EN
    output Ovf,
`endif
    output Diff, Bout, out_valid
  );

endinterface

// File: rtl/ks_prefix_stage.sv
// One Kogge-Stone black-cell level: combines each bit with the bit 'span' positions below.
// Bits below span pass through unchanged.
import ks_pkg::*;

module ks_prefix_stage (
  input  gp_t        gp_in,
  input  logic [4:0] span,
  output gp_t        gp_out
);

  logic [KS_WIDTH-1:0] low_mask;

  always_comb begin
    low_mask  = ({{(KS_WIDTH-1){1'b0}}, 1'b1} << span) - {{(KS_WIDTH-1){1'b0}}, 1'b1};
    gp_out.g  = gp_in.g | (gp_in.p & (gp_in.g << span));
    gp_out.p  = gp_in.p & ((gp_in.p << span) | low_mask);
  end

endmodule

// File: rtl/ks_subtractor.sv
// 6-stage pipelined 16-bit subtractor: A + ~B + ~Bin via Kogge-Stone prefix, Bout = ~carry.
// Define KS_SUB_OVERFLOW_EN to add the registered signed-overflow output Ovf.
import ks_pkg::*;

module ks_subtractor (
  input  logic                clk,
  input  logic                rst,
  ks_subtractor_if.slave      bus
);

  ks_stage_t             stg_in;
  ks_stage_t             stg [KS_LEVELS+1];
  gp_t                   lvl_gp [KS_LEVELS];
  logic [KS_LATENCY-1:0] vld;
  logic [KS_WIDTH-1:0]   diff_next;
  logic [KS_WIDTH-1:0]   diff_q;
  logic                  bout_q;
  logic [KS_WIDTH-1:0]   b_inv;
  logic [KS_WIDTH-1:0]   p_bit;
  logic [KS_WIDTH-1:0]   g_bit;

  // Borrow-in becomes carry-in of the inverted subtrahend, folded into G[0].
  always_comb begin
    b_inv      = ~bus.B;
    p_bit      = bus.A ^ b_inv;
    g_bit      = bus.A & b_inv;
    g_bit[0]   = g_bit[0] | (p_bit[0] & ~bus.Bin);
    stg_in.gp  = '{g: g_bit, p: p_bit};
    stg_in.p0  = p_bit;
    stg_in.cin = ~bus.Bin;
  end

  for (genvar k = 0; k < KS_LEVELS; k++) begin : g_level
    ks_prefix_stage u_stage (
      .gp_in  (stg[k].gp),
      .span   (ks_span(k)),
      .gp_out (lvl_gp[k])
    );
  end

  // Data registers are left unreset; the valid chain masks them.
  always_ff @(posedge clk) begin
    if (bus.ce) begin
      stg[0] <= stg_in;
      for (int k = 0; k < KS_LEVELS; k++) begin
        stg[k+1].gp  <= lvl_gp[k];
        stg[k+1].p0  <= stg[k].p0;
        stg[k+1].cin <= stg[k].cin;
      end
    end
  end

  assign diff_next = stg[KS_LEVELS].p0 ^ {stg[KS_LEVELS].gp.g[KS_WIDTH-2:0], stg[KS_LEVELS].cin};

  always_ff @(posedge clk) begin
    if (rst) begin
      vld    <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
    end else if (bus.ce) begin
      vld    <= {vld[KS_LATENCY-2:0], bus.in_valid};
      diff_q <= diff_next;
      bout_q <= ~stg[KS_LEVELS].gp.g[KS_WIDTH-1];
    end
  end

  assign bus.Diff      = diff_q;
  assign bus.Bout      = bout_q;
  assign bus.out_valid = vld[KS_LATENCY-1];

`ifdef KS_SUB_OVERFLOW_EN
  // Operand sign bits ride alongside the prefix stages: {A[15], B[15]}.
  logic [1:0] msb [KS_LATENCY-1];
  logic       ovf_q;

  always_ff @(posedge clk) begin
    if (bus.ce) begin
      msb[0] <= {bus.A[KS_WIDTH-1], bus.B[KS_WIDTH-1]};
      for (int k = 1; k < KS_LATENCY-1; k++) begin
        msb[k] <= msb[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (bus.ce) begin
      ovf_q <= (msb[KS_LATENCY-2][1] != msb[KS_LATENCY-2][0]) &&
               (diff_next[KS_WIDTH-1] != msb[KS_LATENCY-2][1]);
    end
  end

  assign bus.Ovf = ovf_q;
`endif

endmodule
